// File: rtl/bus_pkg.sv
// Shared types and constants for the external bus cycle controller.
package bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } bus_state_e;

    localparam int unsigned REGION_LSB  = 22;
    localparam int unsigned REGION_BITS = 3;
    localparam int unsigned NUM_REGIONS = 8;
    localparam int unsigned WAIT_W      = 4;
    localparam int unsigned TMO_W       = 8;

    // Pick the wait-state nibble that belongs to one address region.
    function automatic logic [WAIT_W-1:0] wait_nibble(
        input logic [NUM_REGIONS*WAIT_W-1:0] waits,
        input logic [REGION_BITS-1:0]        region
    );
        return waits[region*WAIT_W +: WAIT_W];
    endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// Wait-state down-counter and strobe-length counter for one bus cycle.
module bus_wait_cnt
    import bus_pkg::*;
#(
    parameter logic [TMO_W-1:0] TMO_CYCLES = 8'd255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_active,
    input  logic              i_wait_n,
    output logic              o_done,
    output logic              o_tmo
);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic [TMO_W-1:0]  r_len_cnt;

    // Load at strobe entry; count down wait states and count strobe length while active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_len_cnt  <= '0;
        end else if (i_load) begin
            r_wait_cnt <= i_load_val;
            r_len_cnt  <= '0;
        end else if (i_active) begin
            if (r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            r_len_cnt <= r_len_cnt + 1'b1;
        end
    end

    // Device wait is only honoured once the programmed wait states have elapsed.
    assign o_done = (r_wait_cnt == '0) && i_wait_n;
    // Asserted during the TMO_CYCLES-th strobe cycle.
    assign o_tmo  = (r_len_cnt == TMO_W'(TMO_CYCLES - 1'b1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// CPU-side external bus cycle controller: setup, strobe with wait states, hold/ack.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter logic [NUM_REGIONS*WAIT_W-1:0] WAITS      = 32'h0,
    parameter logic [TMO_W-1:0]              TMO_CYCLES = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr_in,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_addr,
    output logic        o_cs_n,
    output logic        o_rd_n,
    output logic        o_wr_n,
    output logic [31:0] o_dout,
    output logic        o_dout_oe,
    input  logic [31:0] i_din,
    input  logic        i_wait_n
);

    bus_state_e       r_state;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_dout;
    logic [31:0]      r_rdata;
    logic             r_dout_oe;
    logic             r_cs_n;
    logic             r_rd_n;
    logic             r_wr_n;
    logic             r_ack;
    logic             r_err;

    logic                   w_mapped;
    logic [REGION_BITS-1:0] w_region;
    logic                   w_load;
    logic                   w_active;
    logic                   w_done;
    logic                   w_tmo;

    assign w_region = r_addr[REGION_LSB +: REGION_BITS];
    assign w_mapped = (r_addr[31:REGION_LSB+REGION_BITS] == '0);
    assign w_load   = (r_state == StSetup) && w_mapped;
    assign w_active = (r_state == StStrobe);

    bus_wait_cnt #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_wait_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (wait_nibble(WAITS, w_region)),
        .i_active   (w_active),
        .i_wait_n   (i_wait_n),
        .o_done     (w_done),
        .o_tmo      (w_tmo)
    );

    // Bus cycle sequencer; every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_rdata   <= '0;
            r_dout_oe <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_addr    <= i_addr_in;
                        r_we      <= i_we;
                        r_dout    <= i_wdata;
                        r_dout_oe <= i_we;
                        r_state   <= StSetup;
                    end
                end
                StSetup: begin
                    if (w_mapped) begin
                        r_cs_n  <= 1'b0;
                        r_rd_n  <= r_we;
                        r_wr_n  <= ~r_we;
                        r_state <= StStrobe;
                    end else begin
                        // Unmapped: skip the strobe entirely.
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= StHold;
                    end
                end
                StStrobe: begin
                    if (w_done || w_tmo) begin
                        r_cs_n  <= 1'b1;
                        r_rd_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_ack   <= 1'b1;
                        // Normal completion wins if it coincides with the timeout.
                        r_err   <= ~w_done;
                        r_state <= StHold;
                        if (w_done && !r_we) begin
                            r_rdata <= i_din;
                        end
                    end
                end
                StHold: begin
                    r_ack     <= 1'b0;
                    r_err     <= 1'b0;
                    r_dout_oe <= 1'b0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ack     = r_ack;
    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign o_addr    = r_addr;
    assign o_cs_n    = r_cs_n;
    assign o_rd_n    = r_rd_n;
    assign o_wr_n    = r_wr_n;
    assign o_dout    = r_dout;
    assign o_dout_oe = r_dout_oe;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: expectations queued at request, checked at ack.
module tb_bus_cycle_ctrl;

    localparam logic [31:0] WAITS = 32'h0030_0100; // region0=0, region2=1, region5=3
    localparam logic [7:0]  TMO   = 8'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata = '0;
    logic        ack, err;
    logic [31:0] rdata, addr, dout;
    logic        cs_n, rd_n, wr_n, dout_oe;
    logic [31:0] din = '0;
    logic        wait_n = 1'b1;

    bus_cycle_ctrl #(
        .WAITS      (WAITS),
        .TMO_CYCLES (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_we      (we),
        .i_addr_in (addr_in),
        .i_wdata   (wdata),
        .o_ack     (ack),
        .o_err     (err),
        .o_rdata   (rdata),
        .o_addr    (addr),
        .o_cs_n    (cs_n),
        .o_rd_n    (rd_n),
        .o_wr_n    (wr_n),
        .o_dout    (dout),
        .o_dout_oe (dout_oe),
        .i_din     (din),
        .i_wait_n  (wait_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc;
        int unsigned lat;
        logic        err;
        logic [31:0] rdata;
        int unsigned strobe;
        logic        we;
        logic [31:0] addr;
        logic [31:0] dout;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned n_cs = 0, n_rd = 0, n_wr = 0, n_oe = 0;
    logic [31:0] model_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: accumulate strobe activity, compare on each ack.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_cs = 0; n_rd = 0; n_wr = 0; n_oe = 0;
        end else begin
            if (!cs_n)   n_cs++;
            if (!rd_n)   n_rd++;
            if (!wr_n)   n_wr++;
            if (dout_oe) n_oe++;
            if (ack) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("ack_latency", cyc - e.acc + 1, e.lat);
                    check_eq("err", 32'(err), 32'(e.err));
                    check_eq("rdata", rdata, e.rdata);
                    check_eq("addr", addr, e.addr);
                    check_eq("cs_len", n_cs, e.strobe);
                    check_eq("rd_len", n_rd, e.we ? 0 : e.strobe);
                    check_eq("wr_len", n_wr, e.we ? e.strobe : 0);
                    check_eq("oe_len", n_oe, e.we ? e.strobe + 2 : 0);
                    if (e.we) check_eq("dout", dout, e.dout);
                end
                n_cs = 0; n_rd = 0; n_wr = 0; n_oe = 0;
            end
        end
    end

    // One bus transaction. n_wait: programmed wait count of the region;
    // wait_lo: strobe cycles with wait_ low; stuck: wait_ never rises.
    task automatic issue(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] t_din, input int unsigned n_wait,
                         input int unsigned wait_lo, input logic stuck, input logic hold_req);
        exp_t e;
        logic mapped;
        int unsigned k;
        logic hr_done;
        mapped  = (t_addr[31:25] == 7'd0);
        e.we    = t_we;
        e.addr  = t_addr;
        e.dout  = t_wdata;
        if (!mapped) begin
            e.strobe = 0;
            e.err    = 1'b1;
        end else if (stuck) begin
            e.strobe = TMO;
            e.err    = 1'b1;
        end else begin
            e.strobe = ((n_wait > wait_lo) ? n_wait : wait_lo) + 1;
            e.err    = 1'b0;
            if (!t_we) model_rdata = t_din;
        end
        e.lat   = e.strobe + 2;
        e.rdata = model_rdata;

        din     = t_din;
        wait_n  = !(stuck || wait_lo != 0);
        we      = t_we;
        addr_in = t_addr;
        wdata   = t_wdata;
        req     = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        e.acc = cyc;
        sb_q.push_back(e);

        if (!stuck && wait_lo != 0) begin
            k = 0;
            for (int i = 0; i < 200 && k < wait_lo; i++) begin
                @(negedge clk);
                if (!cs_n) k++;
            end
            @(posedge clk);
            #1;
            wait_n = 1'b1;
        end

        hr_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (hold_req && ack && !hr_done) begin
                req     = 1'b1;
                hr_done = 1'b1;
            end else begin
                req = 1'b0;
            end
            if (sb_q.size() == 0 && !req) break;
        end
        if (sb_q.size() != 0) begin
            check_eq("ack_missing", sb_q.size(), 0);
            sb_q.delete();
        end
        wait_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cs", 32'(cs_n), 32'd1);
        check_eq("rst_rd", 32'(rd_n), 32'd1);
        check_eq("rst_wr", 32'(wr_n), 32'd1);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_oe", 32'(dout_oe), 32'd0);
        check_eq("rst_addr", addr, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Zero-wait read, region 0
        issue(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        // Write in region 5 with 3 wait states
        issue(1'b1, 32'h0140_0000, 32'h1234_5678, 32'h0, 3, 0, 1'b0, 1'b0);
        // Region 2 read, device holds wait_ low for 10 strobe cycles
        issue(1'b0, 32'h0080_0000, 32'h0, 32'hCAFE_F00D, 1, 10, 1'b0, 1'b0);
        // wait_ stuck low: timeout, rdata keeps previous value
        issue(1'b0, 32'h0000_2000, 32'h0, 32'h5555_5555, 0, 0, 1'b1, 1'b0);
        // Unmapped read and write
        issue(1'b0, 32'h0200_0000, 32'h0, 32'hAAAA_AAAA, 0, 0, 1'b0, 1'b0);
        issue(1'b1, 32'h8000_0004, 32'hA5A5_0F0F, 32'h0, 0, 0, 1'b0, 1'b0);
        // Region 5 read with req pulsed during HOLD: the extra req must be dropped
        issue(1'b0, 32'h0150_0010, 32'h0, 32'h0BAD_CAFE, 3, 0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #2;
        check_eq("hold_req_ignored", n_cs, 0);

        // Reset asserted mid-strobe
        din     = 32'h7777_7777;
        wait_n  = 1'b0;
        we      = 1'b0;
        addr_in = 32'h0000_3000;
        req     = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int i = 0; i < 10 && cs_n; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("strobe_started", 32'(cs_n), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_cs", 32'(cs_n), 32'd1);
        check_eq("async_rst_rd", 32'(rd_n), 32'd1);
        check_eq("async_rst_ack", 32'(ack), 32'd0);
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdata_clr", rdata, 32'd0);
        wait_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_eq("no_ack_after_rst", 32'(ack), 32'd0);
        // Fresh read after reset completes normally
        issue(1'b0, 32'h0000_1008, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
